router_rr_input_arbiter: RTL and testbench
==========================================

Name: router_rr_input_arbiter

Overview:
- Parametrised successor to the single-input router input arbiter.
- Arbitrates NUM_REQ router input channels. Each channel presents a start request plus 10-bit-style src/dst addresses.
- Uses round-robin priority and locks the grant until the consumer releases it or a watchdog expires.
- Sits between the router input buffers and the crossbar/route-compute stage. The granted channel's addresses are forwarded as registered outputs.

Parameters:
- NUM_REQ, 4, number of requesting input channels (2..16).
- ADDR_W, 10, width of each src/dst address.
- IDX_W, $clog2(NUM_REQ), width of granted-index output.
- TIMEOUT, 32, max cycles a grant is held without release. 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- router_start_req  in  NUM_REQ  per-channel request, level-sensitive.
- router_scr_addr  in  NUM_REQ*ADDR_W  flattened source addresses; channel i at [i*ADDR_W +: ADDR_W].
- router_dst_addr  in  NUM_REQ*ADDR_W  flattened destination addresses, same packing.
- router_release  in  1  consumer finished with the current grant.
- gnt  out  NUM_REQ  one-hot grant.
- gnt_valid  out  1  a grant is active.
- gnt_idx  out  IDX_W  index of the granted channel.
- gnt_scr_addr  out  ADDR_W  latched source address of the granted channel.
- gnt_dst_addr  out  ADDR_W  latched destination address of the granted channel.
- timeout_err  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ptr=0, hold counter=0. All outputs are 0.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE:
  - If router_start_req != 0, select the first set bit searching from ptr upward with wrap (ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1).
  - On that clock edge: gnt=onehot(sel), gnt_idx=sel, gnt_valid=1. Latch the addresses of sel into gnt_scr_addr/gnt_dst_addr. Clear the counter. Go to BUSY.
  - Latency: request seen at edge N gives the grant visible after edge N (one cycle).
- BUSY:
  - Outputs are held stable. The counter increments each cycle.
  - Changes on router_start_req or the address inputs are ignored; addresses are latched only.
  - router_release=1 → go to RELEASE next edge.
  - TIMEOUT!=0 and counter==TIMEOUT-1 without release → go to RELEASE and pulse timeout_err for exactly one cycle (the RELEASE cycle).
  - Release and timeout on the same cycle: treat as release, no timeout_err.
- RELEASE:
  - gnt=0, gnt_valid=0, gnt_idx and address outputs cleared to 0.
  - ptr = (granted idx + 1) mod NUM_REQ.
  - Return to IDLE. This leaves exactly one dead cycle between consecutive grants.
- router_release in IDLE or RELEASE is ignored.
- Requester holding router_start_req high after release competes again but has the lowest priority (round-robin fairness).
- Only one grant at a time. gnt is always zero or one-hot, never multi-hot.
- Reset mid-BUSY: outputs drop to 0 immediately (async) and ptr returns to 0.

Test Plan (NUM_REQ=4, ADDR_W=10, TIMEOUT=16):
- Single request: reset 2 cycles, then req=4'b0010, scr=0x1, dst=0x5, release after 5 cycles → gnt=4'b0010, gnt_idx=1, gnt_scr_addr=0x001, gnt_dst_addr=0x005 one cycle after req. Outputs clear the cycle after release and ptr=2.
- Round-robin: req=4'b1111 held, release each grant after 3 cycles → grant order 0,1,2,3,0 with one idle cycle between grants.
- Address latch: during a grant to ch2 (scr=0x2, dst=0x6), change ch2 addresses to 0x3FF → gnt_scr_addr/gnt_dst_addr stay 0x002/0x006 until release.
- Watchdog: grant ch0 with no release → after 16 BUSY cycles timeout_err=1 for one cycle, gnt=0, and the next grant goes to ch1 if requesting.
- Simultaneous release and timeout: assert router_release on cycle 16 of BUSY → normal release, timeout_err stays 0.
- Reset mid-grant: drop rst_n during BUSY on ch3 (scr=0x0, dst=0x4) → all outputs 0 asynchronously. After reset, req=4'b1001 grants ch0 (ptr=0).

Source files
------------

// File: rtl/router_rr_input_arbiter_if.sv
// router_rr_input_arbiter_if: request/address bundle from the input buffers and the grant bundle to route-compute.
interface router_rr_input_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = 10,
  parameter int IDX_W = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] router_start_req;
  logic [NUM_REQ*ADDR_W-1:0] router_scr_addr;
  logic [NUM_REQ*ADDR_W-1:0] router_dst_addr;
  logic router_release;
  logic [NUM_REQ-1:0] gnt;
  logic gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [ADDR_W-1:0] gnt_scr_addr;
  logic [ADDR_W-1:0] gnt_dst_addr;
  logic timeout_err;
  modport master (
    output router_start_req, router_scr_addr, router_dst_addr, router_release,
    input gnt, gnt_valid, gnt_idx, gnt_scr_addr, gnt_dst_addr, timeout_err
  );
  modport slave (
    input router_start_req, router_scr_addr, router_dst_addr, router_release,
    output gnt, gnt_valid, gnt_idx, gnt_scr_addr, gnt_dst_addr, timeout_err
  );
endinterface

// File: rtl/router_rr_input_arbiter.sv
// router_rr_input_arbiter: round-robin arbiter over NUM_REQ router inputs with locked grant, latched addresses and a watchdog.
module router_rr_input_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = 10,
  parameter int TIMEOUT = 32,
  parameter int IDX_W = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst_n,
  router_rr_input_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam int CNT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [1:0] state;
  logic [IDX_W-1:0] ptr, sel, cand;
  logic [CNT_W-1:0] cnt;
  logic expire;
  always_comb begin
    sel = '0;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      sel = bus.router_start_req[cand] ? cand : sel;
    end
  end
  assign expire = TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1);
  // RELEASE is the single dead cycle; it may already launch the next grant with the rotated pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      bus.gnt <= '0;
      bus.gnt_valid <= 1'b0;
      bus.gnt_idx <= '0;
      bus.gnt_scr_addr <= '0;
      bus.gnt_dst_addr <= '0;
      bus.timeout_err <= 1'b0;
    end else if (state == BUSY) begin
      if (bus.router_release || expire) begin
        state <= RELEASE;
        ptr <= bus.gnt_idx == IDX_W'(NUM_REQ - 1) ? '0 : bus.gnt_idx + 1'b1;
        bus.gnt <= '0;
        bus.gnt_valid <= 1'b0;
        bus.gnt_idx <= '0;
        bus.gnt_scr_addr <= '0;
        bus.gnt_dst_addr <= '0;
        bus.timeout_err <= !bus.router_release;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      bus.timeout_err <= 1'b0;
      if (|bus.router_start_req) begin
        state <= BUSY;
        cnt <= '0;
        bus.gnt <= NUM_REQ'(1) << sel;
        bus.gnt_valid <= 1'b1;
        bus.gnt_idx <= sel;
        bus.gnt_scr_addr <= bus.router_scr_addr[int'(sel)*ADDR_W +: ADDR_W];
        bus.gnt_dst_addr <= bus.router_dst_addr[int'(sel)*ADDR_W +: ADDR_W];
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_router_rr_input_arbiter.sv
// tb_router_rr_input_arbiter: directed plan plus random traffic checked against a transaction-level arbiter model.
module tb_router_rr_input_arbiter;
  localparam int N = 4;
  localparam int AW = 10;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_err = 0;
  bit m_v;
  int m_idx, m_ptr, m_hold;
  logic [AW-1:0] m_s, m_d;
  bit m_to;
  always #5 clk = ~clk;
  router_rr_input_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW)) bus ();
  router_rr_input_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_v = 0;
    m_idx = 0;
    m_ptr = 0;
    m_hold = 0;
    m_s = '0;
    m_d = '0;
    m_to = 0;
  endtask
  task automatic model_edge();
    m_to = 0;
    if (m_v) begin
      m_hold++;
      if (bus.router_release || m_hold == TO) begin
        m_to = !bus.router_release;
        m_ptr = (m_idx + 1) % N;
        m_v = 0;
        m_idx = 0;
        m_s = '0;
        m_d = '0;
      end
    end else if (bus.router_start_req != '0) begin
      for (int k = N - 1; k >= 0; k--)
        if (bus.router_start_req[(m_ptr + k) % N]) m_idx = (m_ptr + k) % N;
      m_v = 1;
      m_hold = 0;
      m_s = bus.router_scr_addr[m_idx*AW +: AW];
      m_d = bus.router_dst_addr[m_idx*AW +: AW];
    end
  endtask
  task automatic compare_all(input string tag);
    chk({tag, ".gnt"}, 32'(bus.gnt), m_v ? 32'(1) << m_idx : 32'd0);
    chk({tag, ".valid"}, 32'(bus.gnt_valid), 32'(m_v));
    chk({tag, ".idx"}, 32'(bus.gnt_idx), 32'(m_idx));
    chk({tag, ".scr"}, 32'(bus.gnt_scr_addr), 32'(m_s));
    chk({tag, ".dst"}, 32'(bus.gnt_dst_addr), 32'(m_d));
    chk({tag, ".terr"}, 32'(bus.timeout_err), 32'(m_to));
    chk({tag, ".onehot"}, 32'($onehot0(bus.gnt)), 32'd1);
  endtask
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic set_addr(input int c, input logic [AW-1:0] s, input logic [AW-1:0] d);
    bus.router_scr_addr[c*AW +: AW] = s;
    bus.router_dst_addr[c*AW +: AW] = d;
  endtask
  initial begin
    bus.router_start_req = '0;
    bus.router_scr_addr = '0;
    bus.router_dst_addr = '0;
    bus.router_release = 1'b0;
    do_reset();
    chk("reset_gnt", 32'(bus.gnt), 32'd0);
    // single request on ch1
    bus.router_start_req = 4'b0010;
    set_addr(1, 10'h001, 10'h005);
    cycle("single");
    chk("single_gnt", 32'(bus.gnt), 32'h2);
    chk("single_idx", 32'(bus.gnt_idx), 32'd1);
    chk("single_scr", 32'(bus.gnt_scr_addr), 32'h001);
    chk("single_dst", 32'(bus.gnt_dst_addr), 32'h005);
    bus.router_start_req = '0;
    repeat (4) cycle("single_hold");
    bus.router_release = 1'b1;
    cycle("single_rel");
    bus.router_release = 1'b0;
    chk("single_clear", 32'(bus.gnt_valid), 32'd0);
    bus.router_start_req = 4'b0101;
    cycle("ptr2");
    chk("ptr2_idx", 32'(bus.gnt_idx), 32'd2);
    bus.router_start_req = '0;
    bus.router_release = 1'b1;
    cycle("ptr2_rel");
    bus.router_release = 1'b0;
    // round robin with all channels requesting
    do_reset();
    bus.router_start_req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      cycle("rr_gnt");
      chk("rr_order", 32'(bus.gnt_idx), 32'(g % N));
      cycle("rr_hold");
      bus.router_release = 1'b1;
      cycle("rr_rel");
      bus.router_release = 1'b0;
      chk("rr_dead", 32'(bus.gnt_valid), 32'd0);
    end
    // address latch
    do_reset();
    bus.router_start_req = 4'b0100;
    set_addr(2, 10'h002, 10'h006);
    cycle("latch");
    set_addr(2, 10'h3FF, 10'h3FF);
    repeat (3) cycle("latch_hold");
    chk("latch_scr", 32'(bus.gnt_scr_addr), 32'h002);
    chk("latch_dst", 32'(bus.gnt_dst_addr), 32'h006);
    bus.router_start_req = '0;
    bus.router_release = 1'b1;
    cycle("latch_rel");
    bus.router_release = 1'b0;
    // watchdog on ch0, then ch1 takes over
    do_reset();
    bus.router_start_req = 4'b0001;
    cycle("wd_gnt");
    bus.router_start_req = 4'b0011;
    repeat (15) cycle("wd_busy");
    chk("wd_quiet", 32'(bus.timeout_err), 32'd0);
    cycle("wd_fire");
    chk("wd_terr", 32'(bus.timeout_err), 32'd1);
    chk("wd_gnt0", 32'(bus.gnt), 32'd0);
    cycle("wd_next");
    chk("wd_terr_pulse", 32'(bus.timeout_err), 32'd0);
    chk("wd_next_gnt", 32'(bus.gnt), 32'h2);
    // release coinciding with watchdog expiry
    bus.router_start_req = '0;
    repeat (15) cycle("sim_busy");
    bus.router_release = 1'b1;
    cycle("sim_rel");
    bus.router_release = 1'b0;
    chk("sim_terr", 32'(bus.timeout_err), 32'd0);
    chk("sim_valid", 32'(bus.gnt_valid), 32'd0);
    // asynchronous reset during a grant
    do_reset();
    bus.router_start_req = 4'b1000;
    set_addr(3, 10'h000, 10'h004);
    cycle("mid");
    chk("mid_gnt", 32'(bus.gnt), 32'h8);
    do_reset();
    bus.router_start_req = 4'b1001;
    cycle("mid_after");
    chk("mid_after_gnt", 32'(bus.gnt), 32'h1);
    bus.router_start_req = '0;
    bus.router_release = 1'b1;
    cycle("mid_rel");
    bus.router_release = 1'b0;
    // random traffic
    for (int t = 0; t < 600; t++) begin
      bus.router_start_req = N'($urandom);
      bus.router_scr_addr = (N*AW)'({$urandom(), $urandom()});
      bus.router_dst_addr = (N*AW)'({$urandom(), $urandom()});
      bus.router_release = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
